pipe_load_unit: RTL

//  Load-side companion to the store pipeline: reads 16-bit words back from the

---
 rtl/pipe_load_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_load_unit.sv
// pipe_load_unit
// Load-side companion to the store pipeline. It reads DW-bit words back from
// its own data memory, formats them, and writes the results into its own
// register bank. The pipeline has three stages:
//    S1 request latch -> S2 registered memory read -> S3 format / writeback.
//
// Optional feature (macro LOAD_FWD_EN):
//    defined   : if the memory write port writes the address that S1 holds on
//                the edge where S2 captures, S2 takes the incoming write data
//                (write-first forwarding).
//    undefined : read-first. S2 gets the word that was in memory before the write.
//
// Ports
//    clk, rst            clock and asynchronous active-high reset
//    in_valid/in_ready   load request handshake
//    rd, addr, func      destination register, memory address, format select
//    mem_we/waddr/wdata  memory write port (also active during a stall)
//    out_valid/out_ready result handshake; writeback happens on the handshake
//    out_rd, out_data    destination register and formatted data
//    out_err             unsupported func; out_data is forced to 0
//    dbg_rs/dbg_data     combinational register-bank debug read
module pipe_load_unit #(
   parameter int AW = 8,
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [RW-1:0] rd,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    func,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_waddr,
   input  logic [DW-1:0] mem_wdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_rd,
   output logic [DW-1:0] out_data,
   output logic          out_err,
   input  logic [RW-1:0] dbg_rs,
   output logic [DW-1:0] dbg_data
);

   localparam int HW    = DW / 2;
   localparam int DEPTH = 1 << AW;
   localparam int NREG  = 1 << RW;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] regbank [NREG];

   logic          stall;

   logic          s1_valid;
   logic [RW-1:0] s1_rd;
   logic [AW-1:0] s1_addr;
   logic [3:0]    s1_func;

   logic          s2_valid;
   logic [RW-1:0] s2_rd;
   logic [3:0]    s2_func;
   logic [DW-1:0] s2_word;

   logic [DW-1:0] fmt_data;
   logic          fmt_err;
   logic [HW-1:0] lo_half;
   logic [HW-1:0] hi_half;

   // A result that the consumer refuses freezes the whole pipeline, so the
   // request side is only ready when nothing downstream is blocked.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign dbg_data = regbank[dbg_rs];

   // Memory array and the S2 read register. The memory is never reset, and
   // the write port stays live during a stall. S2 does not re-read while
   // stalled, so a write under a stall cannot corrupt the word already held.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (!stall) begin
`ifdef LOAD_FWD_EN
         if (mem_we && (mem_waddr == s1_addr)) begin
            s2_word <= mem_wdata;
         end else begin
            s2_word <= mem[s1_addr];
         end
`else
         s2_word <= mem[s1_addr];
`endif
      end
   end

   // Format S2's word for the output stage. Unknown func codes give a zero
   // result with the error flag set, and the result is still written back.
   always_comb begin
      fmt_data = '0;
      fmt_err  = 1'b0;
      lo_half  = s2_word[HW-1:0];
      hi_half  = s2_word[DW-1:HW];
      case (s2_func)
         4'd0: fmt_data = s2_word;
         4'd1: fmt_data = {{HW{1'b0}}, lo_half};
         4'd2: fmt_data = {{HW{1'b0}}, hi_half};
         4'd3: fmt_data = {{HW{lo_half[HW-1]}}, lo_half};
         4'd4: fmt_data = {{HW{hi_half[HW-1]}}, hi_half};
         4'd5: fmt_data = s2_word >> 1;
         4'd6: fmt_data = s2_word << 1;
         default: begin
            fmt_data = '0;
            fmt_err  = 1'b1;
         end
      endcase
   end

   // Pipeline control and payload registers. All stages advance together
   // when there is no stall. Bubbles move along with the valid loads and are
   // not squeezed out, so ordering and latency stay fixed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_rd     <= '0;
         s1_addr   <= '0;
         s1_func   <= '0;
         s2_valid  <= 1'b0;
         s2_rd     <= '0;
         s2_func   <= '0;
         out_valid <= 1'b0;
         out_rd    <= '0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (!stall) begin
         s1_valid  <= in_valid;
         s1_rd     <= rd;
         s1_addr   <= addr;
         s1_func   <= func;
         s2_valid  <= s1_valid;
         s2_rd     <= s1_rd;
         s2_func   <= s1_func;
         out_valid <= s2_valid;
         out_rd    <= s2_rd;
         out_data  <= fmt_data;
         out_err   <= fmt_err;
      end
   end

   // Register bank. A write happens only on the result handshake. Because
   // this update is registered, the debug port shows the old value until
   // the edge has passed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regbank[i] <= '0;
         end
      end else if (out_valid && out_ready) begin
         regbank[out_rd] <= out_data;
      end
   end

endmodule
